// File: rtl/sobel_frame_scheduler.sv
// rtl/sobel_frame_scheduler.sv - frame-level read/stream sequencer feeding sobel_detector
//
// Purpose:
//   On an accepted start, reads one IMG_H_DISP x IMG_V_DISP grey frame from a
//   synchronous frame-buffer port and streams it to the detector as
//   per_img_vsync/href/gray with V_FRONT cycles of leading vsync and H_BLANK
//   cycles of blanking between lines. The threshold is latched for the whole
//   frame. Completion is reported only after the detector's post_img_vsync
//   falls, so the last processed pixel has left the detector pipeline.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               one-cycle frame request, honoured only when idle
//   thresh_in           threshold, sampled on an accepted start
//   busy                high from the cycle after an accepted start until frame_done
//   frame_done          one-cycle completion pulse
//   mem_rd_en           frame-buffer read strobe
//   mem_rd_addr         read address, row*IMG_H_DISP+col
//   mem_rd_data         read data, valid one cycle after mem_rd_en
//   per_img_vsync       frame valid to detector
//   per_img_href        pixel valid to detector (mem_rd_en delayed one cycle)
//   per_img_gray        pixel to detector, zero outside href
//   thresh              latched threshold to detector
//   post_img_vsync      detector output vsync

module sobel_frame_scheduler #(
    parameter int IMG_H_DISP = 512,
    parameter int IMG_V_DISP = 512,
    parameter int V_FRONT    = 5,
    parameter int H_BLANK    = 10,
    parameter int ADDR_W     = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        thresh_in,
    output logic              busy,
    output logic              frame_done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              per_img_vsync,
    output logic              per_img_href,
    output logic [7:0]        per_img_gray,
    output logic [7:0]        thresh,
    input  logic              post_img_vsync
);

    localparam int COL_W   = $clog2(IMG_H_DISP);
    localparam int ROW_W   = $clog2(IMG_V_DISP);
    localparam int BLK_MAX = (V_FRONT > H_BLANK) ? V_FRONT : H_BLANK;
    localparam int BLK_W   = $clog2(BLK_MAX + 1);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_H_DISP - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_V_DISP - 1);
    localparam logic [BLK_W-1:0] VF_LAST  = BLK_W'(V_FRONT - 1);
    localparam logic [BLK_W-1:0] HB_LAST  = BLK_W'(H_BLANK - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VFRONT,
        S_LINE,
        S_HBLANK,
        S_TAIL,
        S_WAIT_POST
    } state_t;

    state_t            state_q;
    logic              busy_q;
    logic              frame_done_q;
    logic              rd_en_q;
    logic [ADDR_W-1:0] addr_q;
    logic              vsync_q;
    logic              href_q;
    logic [7:0]        thresh_q;
    logic              post_q;
    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic [BLK_W-1:0]  blk_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            rd_en_q      <= 1'b0;
            addr_q       <= '0;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            thresh_q     <= 8'd0;
            post_q       <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            blk_q        <= '0;
        end else begin
            frame_done_q <= 1'b0;
            post_q       <= post_img_vsync;
            // Read data returns one cycle after the strobe, so href trails rd_en by one.
            href_q       <= rd_en_q;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q  <= S_VFRONT;
                        busy_q   <= 1'b1;
                        vsync_q  <= 1'b1;
                        thresh_q <= thresh_in;
                        addr_q   <= '0;
                        col_q    <= '0;
                        row_q    <= '0;
                        blk_q    <= '0;
                    end
                end

                S_VFRONT: begin
                    if (blk_q == VF_LAST) begin
                        state_q <= S_LINE;
                        rd_en_q <= 1'b1;
                        blk_q   <= '0;
                    end else begin
                        blk_q <= blk_q + BLK_W'(1);
                    end
                end

                S_LINE: begin
                    if (col_q == COL_LAST) begin
                        col_q   <= '0;
                        rd_en_q <= 1'b0;
                        if (row_q == ROW_LAST) begin
                            // Address parks on the final pixel of the frame.
                            state_q <= S_TAIL;
                        end else begin
                            row_q   <= row_q + ROW_W'(1);
                            addr_q  <= addr_q + ADDR_W'(1);
                            state_q <= S_HBLANK;
                        end
                    end else begin
                        col_q  <= col_q + COL_W'(1);
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end

                S_HBLANK: begin
                    if (blk_q == HB_LAST) begin
                        state_q <= S_LINE;
                        rd_en_q <= 1'b1;
                        blk_q   <= '0;
                    end else begin
                        blk_q <= blk_q + BLK_W'(1);
                    end
                end

                S_TAIL: begin
                    // This cycle carries the last href; vsync drops after it.
                    vsync_q <= 1'b0;
                    state_q <= S_WAIT_POST;
                end

                S_WAIT_POST: begin
                    // The done-pulse cycle still belongs to this state so a start
                    // coinciding with frame_done is not accepted.
                    if (frame_done_q) begin
                        state_q <= S_IDLE;
                    end else if (post_q && !post_img_vsync) begin
                        frame_done_q <= 1'b1;
                        busy_q       <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign frame_done    = frame_done_q;
    assign mem_rd_en     = rd_en_q;
    assign mem_rd_addr   = addr_q;
    assign per_img_vsync = vsync_q;
    assign per_img_href  = href_q;
    assign per_img_gray  = href_q ? mem_rd_data : 8'd0;
    assign thresh        = thresh_q;

endmodule

// File: tb/tb_sobel_frame_scheduler.sv
// tb/tb_sobel_frame_scheduler.sv - directed table-driven bench for sobel_frame_scheduler

module tb_sobel_frame_scheduler;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int VF = 2;
    localparam int HB = 3;
    localparam int AW = 18;

    localparam int S1    = 2;
    localparam int S2    = S1 + 31;
    localparam int NROWS = S2 + 31;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [7:0]    thresh_in;
    logic          busy;
    logic          frame_done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [7:0]    mem_rd_data;
    logic          per_img_vsync;
    logic          per_img_href;
    logic [7:0]    per_img_gray;
    logic [7:0]    thresh;
    logic          post_img_vsync;

    logic          post_hold;
    logic [6:0]    pv;

    int vec_count = 0;
    int err_count = 0;

    typedef struct {
        logic       start;
        logic [7:0] thr_in;
        logic       busy;
        logic       done;
        logic       vsync;
        logic       rd_en;
        int         addr;
        logic       href;
        logic [7:0] gray;
        logic [7:0] thresh;
    } vec_t;

    vec_t tbl [NROWS];

    sobel_frame_scheduler #(
        .IMG_H_DISP(H),
        .IMG_V_DISP(V),
        .V_FRONT   (VF),
        .H_BLANK   (HB),
        .ADDR_W    (AW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .thresh_in     (thresh_in),
        .busy          (busy),
        .frame_done    (frame_done),
        .mem_rd_en     (mem_rd_en),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_data   (mem_rd_data),
        .per_img_vsync (per_img_vsync),
        .per_img_href  (per_img_href),
        .per_img_gray  (per_img_gray),
        .thresh        (thresh),
        .post_img_vsync(post_img_vsync)
    );

    always #5 clk = ~clk;

    // Frame buffer: mem[i] = i + 8'h10, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= 8'h10 + mem_rd_addr[7:0];
    end

    // Detector stand-in: post vsync is per_img_vsync delayed 7 cycles.
    always @(posedge clk) begin
        if (!rst_n) pv <= 7'd0;
        else        pv <= {pv[5:0], per_img_vsync};
    end
    assign post_img_vsync = post_hold | pv[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy"},  {31'd0, busy}, 0);
        chk({tag, " done"},  {31'd0, frame_done}, 0);
        chk({tag, " rd_en"}, {31'd0, mem_rd_en}, 0);
        chk({tag, " addr"},  32'(mem_rd_addr), 0);
        chk({tag, " vsync"}, {31'd0, per_img_vsync}, 0);
        chk({tag, " href"},  {31'd0, per_img_href}, 0);
        chk({tag, " gray"},  {24'd0, per_img_gray}, 0);
        chk({tag, " thresh"},{24'd0, thresh}, 0);
    endtask

    // Start one frame and follow it to frame_done, checking read order and pixels.
    task automatic run_frame_check(input string tag);
        int  nrd;
        int  npx;
        bit  seen;
        nrd  = 0;
        npx  = 0;
        seen = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            if (mem_rd_en) begin
                chk($sformatf("%s addr%0d", tag, nrd), 32'(mem_rd_addr), 32'(nrd));
                nrd++;
            end
            if (per_img_href) begin
                chk($sformatf("%s gray%0d", tag, npx), {24'd0, per_img_gray}, 32'(8'h10 + npx));
                npx++;
            end
            if (frame_done) seen = 1;
            else tick();
        end
        chk({tag, " done seen"}, {31'd0, seen}, 1);
        chk({tag, " reads"}, 32'(nrd), H * V);
        chk({tag, " hrefs"}, 32'(npx), H * V);
        chk({tag, " busy at done"}, {31'd0, busy}, 0);
    endtask

    task automatic fill_frame(input int b);
        for (int o = 0; o < 30; o++) begin
            int r;
            r = b + o;
            tbl[r].busy  = (o <= 28);
            tbl[r].done  = (o == 29);
            tbl[r].vsync = (o <= 20);
            for (int l = 0; l < V; l++) begin
                int ls;
                ls = VF + l * (H + HB);
                if (o >= ls && o < ls + H) begin
                    tbl[r].rd_en = 1'b1;
                    tbl[r].addr  = l * H + (o - ls);
                end
                if (o - 1 >= ls && o - 1 < ls + H) begin
                    tbl[r].href = 1'b1;
                    tbl[r].gray = 8'(8'h10 + l * H + (o - 1 - ls));
                end
            end
        end
    endtask

    initial begin
        bit ok;
        int dn;

        rst_n     = 1'b0;
        start     = 1'b0;
        thresh_in = 8'd0;
        post_hold = 1'b0;

        for (int r = 0; r < NROWS; r++) begin
            tbl[r].start  = 1'b0;
            tbl[r].thr_in = (r <= S1 + 3) ? 8'd96 : 8'd200;
            tbl[r].busy   = 1'b0;
            tbl[r].done   = 1'b0;
            tbl[r].vsync  = 1'b0;
            tbl[r].rd_en  = 1'b0;
            tbl[r].addr   = 0;
            tbl[r].href   = 1'b0;
            tbl[r].gray   = 8'd0;
            tbl[r].thresh = (r < S1) ? 8'd0 : (r < S2) ? 8'd96 : 8'd200;
        end
        fill_frame(S1);
        fill_frame(S2);
        tbl[S1].start      = 1'b1;
        tbl[S1 + 4].start  = 1'b1;  // during LINE: ignored
        tbl[S1 + 30].start = 1'b1;  // sampled in frame_done cycle: ignored
        tbl[S2].start      = 1'b1;  // first IDLE cycle: accepted

        repeat (10) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;

        for (int r = 0; r < NROWS; r++) begin
            start     = tbl[r].start;
            thresh_in = tbl[r].thr_in;
            tick();
            chk($sformatf("row%0d busy", r),   {31'd0, busy},          {31'd0, tbl[r].busy});
            chk($sformatf("row%0d done", r),   {31'd0, frame_done},    {31'd0, tbl[r].done});
            chk($sformatf("row%0d vsync", r),  {31'd0, per_img_vsync}, {31'd0, tbl[r].vsync});
            chk($sformatf("row%0d rd_en", r),  {31'd0, mem_rd_en},     {31'd0, tbl[r].rd_en});
            if (tbl[r].rd_en)
                chk($sformatf("row%0d addr", r), 32'(mem_rd_addr), 32'(tbl[r].addr));
            chk($sformatf("row%0d href", r),   {31'd0, per_img_href},  {31'd0, tbl[r].href});
            chk($sformatf("row%0d gray", r),   {24'd0, per_img_gray},  {24'd0, tbl[r].gray});
            chk($sformatf("row%0d thresh", r), {24'd0, thresh},        {24'd0, tbl[r].thresh});
        end
        start = 1'b0;
        repeat (5) tick();

        // post_img_vsync held high: frame never completes.
        post_hold = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        dn = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (frame_done) dn++;
        end
        chk("hold busy", {31'd0, busy}, 1);
        chk("hold no done", 32'(dn), 0);
        rst_n = 1'b0;
        tick();
        chk_all_zero("hold reset");
        rst_n     = 1'b1;
        post_hold = 1'b0;
        repeat (12) tick();

        // Reset mid-frame at line 2, pixel 2 (address 10).
        thresh_in = 8'd55;
        start     = 1'b1;
        tick();
        start = 1'b0;
        ok = 0;
        for (int c = 0; c < 100 && !ok; c++) begin
            if (mem_rd_en && mem_rd_addr == AW'(10)) ok = 1;
            else tick();
        end
        chk("reach line2 px2", {31'd0, ok}, 1);
        rst_n = 1'b0;
        tick();
        chk_all_zero("midframe reset");
        rst_n = 1'b1;
        dn = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (frame_done) dn++;
        end
        chk("no done after abort", 32'(dn), 0);
        chk("idle after abort", {31'd0, busy}, 0);

        run_frame_check("post-reset frame");
        chk("post-reset thresh", {24'd0, thresh}, 55);
        tick();
        chk("post-reset done width", {31'd0, frame_done}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
